// File: rtl/pattern_sequencer.sv
// rtl/pattern_sequencer.sv - pattern buffer store and PWM-phase drive sequencer
// Optional dead time before buffer 0 is driven: define PATSEQ_DEADTIME_EN.
module pattern_sequencer #(
  parameter int W      = 7,
  parameter int NBUF   = 8,
  parameter int NTWEAK = 8,
  parameter int DW_W   = 4,
  parameter int DT_W   = 4,
  localparam int NFIELD = 2*NTWEAK + 6,
  localparam int BA_W   = $clog2(NBUF),
  localparam int FA_W   = $clog2(NFIELD)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pwm,
  input  logic [DW_W-1:0]     dwell,
  input  logic [DT_W-1:0]     deadtime,
  input  logic                wr_en,
  input  logic [BA_W-1:0]     wr_buf,
  input  logic [FA_W-1:0]     wr_field,
  input  logic [W-1:0]        wr_data,
  input  logic [BA_W-1:0]     rd_buf,
  input  logic [FA_W-1:0]     rd_field,
  output logic [W-1:0]        rd_data,
  output logic [W-1:0]        p_drive,
  output logic [W-1:0]        n_drive,
  output logic [W-1:0]        tweak_sense,
  output logic [W-1:0]        tweak_delay,
  output logic [NTWEAK*W-1:0] tweak_drive,
  output logic [BA_W-1:0]     buf_idx,
  output logic                phase
);

  localparam int F_PDRIVE = 0;
  localparam int F_NDRIVE = 1;
  localparam int F_PSENSE = 2;
  localparam int F_PDELAY = 3;
  localparam int F_PTWEAK = 4;
  localparam int F_NSENSE = 4 + NTWEAK;
  localparam int F_NDELAY = 5 + NTWEAK;
  localparam int F_NTWEAK = 6 + NTWEAK;
  localparam logic [BA_W-1:0] LAST_BUF = BA_W'(NBUF - 1);

`ifdef PATSEQ_DEADTIME_EN
  typedef enum logic [1:0] {S_IDLE, S_DEAD, S_STEP, S_HOLD} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_STEP, S_HOLD} state_t;
`endif

  state_t            state_q, state_d;
  logic              pwm_q;
  logic              phase_q, phase_d;
  logic [BA_W-1:0]   buf_idx_q, buf_idx_d;
  logic [DW_W-1:0]   dwell_cnt_q, dwell_cnt_d;
  logic [DW_W-1:0]   dwell_lat_q, dwell_lat_d;
`ifdef PATSEQ_DEADTIME_EN
  logic [DT_W-1:0]   dead_cnt_q, dead_cnt_d;
`else
  logic              unused_deadtime;
  assign unused_deadtime = ^deadtime;
`endif

  logic [W-1:0]        mem_q [NBUF][NFIELD];
  logic [W-1:0]        rd_data_q;
  logic [W-1:0]        p_drive_q, p_drive_d;
  logic [W-1:0]        n_drive_q, n_drive_d;
  logic [W-1:0]        sense_q, sense_d;
  logic [W-1:0]        delay_q, delay_d;
  logic [NTWEAK*W-1:0] tweak_q, tweak_d;

  logic pwm_edge;
  logic wr_ok;
  logic rd_ok;
  logic active;

  assign pwm_edge = pwm ^ pwm_q;
  // Zero-extend indices so a power-of-two NFIELD/NBUF still compares correctly.
  assign wr_ok = wr_en && ({1'b0, wr_field} < (FA_W+1)'(NFIELD))
                       && ({1'b0, wr_buf} < (BA_W+1)'(NBUF));
  assign rd_ok = ({1'b0, rd_field} < (FA_W+1)'(NFIELD))
              && ({1'b0, rd_buf} < (BA_W+1)'(NBUF));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NBUF; b++) begin
        for (int f = 0; f < NFIELD; f++) begin
          mem_q[b][f] <= '0;
        end
      end
    end else if (wr_ok) begin
      mem_q[wr_buf][wr_field] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_ok ? mem_q[rd_buf][rd_field] : '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    buf_idx_d   = buf_idx_q;
    dwell_cnt_d = dwell_cnt_q;
    dwell_lat_d = dwell_lat_q;
`ifdef PATSEQ_DEADTIME_EN
    dead_cnt_d  = dead_cnt_q;
`endif
    if (pwm_edge) begin
      // An edge restarts the sequence from any state.
      phase_d     = pwm;
      buf_idx_d   = '0;
      dwell_lat_d = dwell;
      dwell_cnt_d = dwell;
`ifdef PATSEQ_DEADTIME_EN
      dead_cnt_d  = deadtime;
      state_d     = (deadtime == '0) ? S_STEP : S_DEAD;
`else
      state_d     = S_STEP;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
        end
`ifdef PATSEQ_DEADTIME_EN
        S_DEAD: begin
          dead_cnt_d = dead_cnt_q - 1'b1;
          if (dead_cnt_d == '0) begin
            state_d = S_STEP;
          end
        end
`endif
        S_STEP: begin
          if (dwell_cnt_q == '0) begin
            if (buf_idx_q == LAST_BUF) begin
              state_d = S_HOLD;
            end else begin
              buf_idx_d   = buf_idx_q + 1'b1;
              dwell_cnt_d = dwell_lat_q;
            end
          end else begin
            dwell_cnt_d = dwell_cnt_q - 1'b1;
          end
        end
        S_HOLD: begin
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign active = (state_q == S_STEP) || (state_q == S_HOLD);

  always_comb begin
    p_drive_d = '1;
    n_drive_d = '0;
    sense_d   = '0;
    delay_d   = '0;
    tweak_d   = '0;
    if (active) begin
      if (phase_q) begin
        p_drive_d = mem_q[buf_idx_q][F_PDRIVE];
        sense_d   = mem_q[buf_idx_q][F_PSENSE];
        delay_d   = mem_q[buf_idx_q][F_PDELAY];
        for (int k = 0; k < NTWEAK; k++) begin
          tweak_d[k*W +: W] = mem_q[buf_idx_q][F_PTWEAK + k];
        end
      end else begin
        n_drive_d = mem_q[buf_idx_q][F_NDRIVE];
        sense_d   = mem_q[buf_idx_q][F_NSENSE];
        delay_d   = mem_q[buf_idx_q][F_NDELAY];
        for (int k = 0; k < NTWEAK; k++) begin
          tweak_d[k*W +: W] = mem_q[buf_idx_q][F_NTWEAK + k];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pwm_q       <= 1'b0;
      phase_q     <= 1'b0;
      buf_idx_q   <= '0;
      dwell_cnt_q <= '0;
      dwell_lat_q <= '0;
`ifdef PATSEQ_DEADTIME_EN
      dead_cnt_q  <= '0;
`endif
      p_drive_q   <= '1;
      n_drive_q   <= '0;
      sense_q     <= '0;
      delay_q     <= '0;
      tweak_q     <= '0;
    end else begin
      state_q     <= state_d;
      pwm_q       <= pwm;
      phase_q     <= phase_d;
      buf_idx_q   <= buf_idx_d;
      dwell_cnt_q <= dwell_cnt_d;
      dwell_lat_q <= dwell_lat_d;
`ifdef PATSEQ_DEADTIME_EN
      dead_cnt_q  <= dead_cnt_d;
`endif
      p_drive_q   <= p_drive_d;
      n_drive_q   <= n_drive_d;
      sense_q     <= sense_d;
      delay_q     <= delay_d;
      tweak_q     <= tweak_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign p_drive     = p_drive_q;
  assign n_drive     = n_drive_q;
  assign tweak_sense = sense_q;
  assign tweak_delay = delay_q;
  assign tweak_drive = tweak_q;
  assign buf_idx     = buf_idx_q;
  assign phase       = phase_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// tb/tb_pattern_sequencer.sv - self-checking bench for pattern_sequencer
// Vector table, hand sequences and a randomized run against a timeline model.
module tb_pattern_sequencer;
  localparam int W    = 7;
  localparam int NBUF = 8;
  localparam int NT   = 8;
  localparam int NF   = 22;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pwm = 1'b0;
  logic [3:0]  dwell = '0;
  logic [3:0]  deadtime = '0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_buf = '0;
  logic [4:0]  wr_field = '0;
  logic [6:0]  wr_data = '0;
  logic [2:0]  rd_buf = '0;
  logic [4:0]  rd_field = '0;
  logic [6:0]  rd_data, p_drive, n_drive, tweak_sense, tweak_delay;
  logic [55:0] tweak_drive;
  logic [2:0]  buf_idx;
  logic        phase;

  pattern_sequencer dut (
    .clk(clk), .rst(rst), .pwm(pwm), .dwell(dwell), .deadtime(deadtime),
    .wr_en(wr_en), .wr_buf(wr_buf), .wr_field(wr_field), .wr_data(wr_data),
    .rd_buf(rd_buf), .rd_field(rd_field), .rd_data(rd_data),
    .p_drive(p_drive), .n_drive(n_drive), .tweak_sense(tweak_sense),
    .tweak_delay(tweak_delay), .tweak_drive(tweak_drive),
    .buf_idx(buf_idx), .phase(phase)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: the last pwm edge and its latched settings define a timeline.
  logic [6:0] mm [NBUF][NF];
  bit  seen, m_ph, m_pwmq;
  int  e_cyc, m_dw, m_dt, cyc;

  typedef struct {
    bit we; int wb; int wf; int wd; int rb; int rf; int exp_rd;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic int buf_at(input int n);
    int k;
    if (!seen || n < 1 + m_dt) return -1;
    k = (n - 1 - m_dt) / (m_dw + 1);
    return (k > NBUF - 1) ? NBUF - 1 : k;
  endfunction

  task automatic model_reset();
    seen = 0; m_ph = 0; m_pwmq = 0; e_cyc = 0; m_dw = 0; m_dt = 0;
    for (int b = 0; b < NBUF; b++)
      for (int f = 0; f < NF; f++) mm[b][f] = '0;
  endtask

  task automatic step();
    int b, eb;
    logic [6:0] ep, en, es, ed, erd;
    logic [55:0] etw;
    @(posedge clk);
    cyc++;
    b = buf_at(cyc - e_cyc);
    ep = 7'h7F; en = '0; es = '0; ed = '0; etw = '0;
    if (b >= 0) begin
      if (m_ph) begin
        ep = mm[b][0]; es = mm[b][2]; ed = mm[b][3];
        for (int k = 0; k < NT; k++) etw[k*W +: W] = mm[b][4+k];
      end else begin
        en = mm[b][1]; es = mm[b][4+NT]; ed = mm[b][5+NT];
        for (int k = 0; k < NT; k++) etw[k*W +: W] = mm[b][6+NT+k];
      end
    end
    erd = (int'(rd_field) < NF) ? mm[rd_buf][rd_field] : 7'h00;
    if (pwm != m_pwmq) begin
      seen = 1; e_cyc = cyc; m_dw = int'(dwell); m_ph = pwm;
`ifdef PATSEQ_DEADTIME_EN
      m_dt = int'(deadtime);
`else
      m_dt = 0;
`endif
    end
    m_pwmq = pwm;
    if (wr_en && int'(wr_field) < NF) mm[wr_buf][wr_field] = wr_data;
    eb = seen ? buf_at(cyc + 1 - e_cyc) : 0;
    if (eb < 0) eb = 0;
    #1;
    chk("p_drive", 64'(p_drive), 64'(ep));
    chk("n_drive", 64'(n_drive), 64'(en));
    chk("sense", 64'(tweak_sense), 64'(es));
    chk("delay", 64'(tweak_delay), 64'(ed));
    chk("tweak_drive", 64'(tweak_drive), 64'(etw));
    chk("rd_data", 64'(rd_data), 64'(erd));
    chk("buf_idx", 64'(buf_idx), 64'(eb));
    chk("phase", 64'(phase), 64'(m_ph));
  endtask

  task automatic wr(input int b, input int f, input int d);
    wr_en = 1'b1; wr_buf = 3'(b); wr_field = 5'(f); wr_data = 7'(d);
    step();
    wr_en = 1'b0;
  endtask

  task automatic chk_off(input string nm);
    chk({nm, "_p"}, 64'(p_drive), 64'h7F);
    chk({nm, "_n"}, 64'(n_drive), 64'h0);
    chk({nm, "_s"}, 64'(tweak_sense), 64'h0);
    chk({nm, "_d"}, 64'(tweak_delay), 64'h0);
    chk({nm, "_tw"}, 64'(tweak_drive), 64'h0);
    chk({nm, "_buf"}, 64'(buf_idx), 64'h0);
    chk({nm, "_rd"}, 64'(rd_data), 64'h0);
    chk({nm, "_ph"}, 64'(phase), 64'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [55:0] tw_p, tw_n;
    bit found;
    cyc = 0;
    model_reset();
    for (int k = 0; k < NT; k++) begin
      tw_p[k*W +: W] = 7'(k + 'h10);
      tw_n[k*W +: W] = 7'(k + 'h20);
    end

    #12;
    chk_off("reset0");
    @(negedge clk);
    rst = 1'b0;

    // Word port vectors (storage starts at zero).
    tbl[0] = '{1, 5, 13, 'h2A, 5, 13, 'h00};
    tbl[1] = '{0, 0, 0,  'h00, 5, 13, 'h2A};
    tbl[2] = '{1, 5, 22, 'h55, 5, 22, 'h00};
    tbl[3] = '{1, 2, 0,  'h11, 5, 22, 'h00};
    tbl[4] = '{0, 0, 0,  'h00, 2, 0,  'h11};
    tbl[5] = '{1, 2, 0,  'h33, 2, 0,  'h11};
    tbl[6] = '{0, 0, 0,  'h00, 2, 0,  'h33};
    tbl[7] = '{0, 0, 0,  'h00, 5, 13, 'h2A};
    tbl[8] = '{0, 0, 0,  'h00, 5, 31, 'h00};
    for (int i = 0; i < 9; i++) begin
      wr_en = tbl[i].we; wr_buf = 3'(tbl[i].wb); wr_field = 5'(tbl[i].wf);
      wr_data = 7'(tbl[i].wd); rd_buf = 3'(tbl[i].rb); rd_field = 5'(tbl[i].rf);
      step();
      chk("tbl_rd", 64'(rd_data), 64'(tbl[i].exp_rd));
    end
    wr_en = 1'b0;

    for (int b = 0; b < NBUF; b++) begin
      wr(b, 0, b + 1);       wr(b, 1, 'h40 + b);
      wr(b, 2, 'h30 + b);    wr(b, 3, 'h38 + b);
      wr(b, 4 + NT, 'h50 + b); wr(b, 5 + NT, 'h58 + b);
      for (int k = 0; k < NT; k++) begin
        wr(b, 4 + k, 'h10 + k);
        wr(b, 6 + NT + k, 'h20 + k);
      end
    end

    // p phase, dwell 0: one buffer per cycle then hold the last.
    dwell = 4'd0; pwm = 1'b1;
    step();
    chk("seq1_edge_buf", 64'(buf_idx), 64'h0);
    for (int n = 1; n <= 11; n++) begin
      step();
      chk("seq1_p", 64'(p_drive), 64'((n <= 8) ? n : 8));
      chk("seq1_n", 64'(n_drive), 64'h0);
      if (n == 3) begin
        chk("seq1_tweak", 64'(tweak_drive), 64'(tw_p));
        chk("seq1_sense", 64'(tweak_sense), 64'h32);
        chk("seq1_delay", 64'(tweak_delay), 64'h3A);
      end
    end

    // n phase, dwell 2: each buffer held three cycles.
    dwell = 4'd2; pwm = 1'b0;
    step();
    for (int n = 1; n <= 26; n++) begin
      step();
      chk("seq2_n", 64'(n_drive), 64'('h40 + (((n - 1) / 3 > 7) ? 7 : (n - 1) / 3)));
      chk("seq2_p", 64'(p_drive), 64'h7F);
      if (n == 5) begin
        chk("seq2_tweak", 64'(tweak_drive), 64'(tw_n));
        chk("seq2_sense", 64'(tweak_sense), 64'h51);
      end
    end

    // Edge mid-sequence at buf_idx 3 restarts at buffer 0.
    pwm = 1'b1;
    step();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (buf_idx == 3'd3) found = 1;
    end
    chk("restart_wait", 64'(found), 64'h1);
    pwm = 1'b0;
    step();
    chk("restart_buf", 64'(buf_idx), 64'h0);
    for (int n = 1; n <= 4; n++) begin
      step();
      chk("restart_n", 64'(n_drive), 64'((n <= 3) ? 'h40 : 'h41));
      chk("restart_p", 64'(p_drive), 64'h7F);
    end

    // Reset mid-STEP with pwm held high: outputs off, storage lost.
    pwm = 1'b1; dwell = 4'd3; rd_buf = 3'd2; rd_field = 5'd0;
    for (int i = 0; i < 5; i++) step();
    chk("pre_reset_rd", 64'(rd_data), 64'h3);
    rst = 1'b1;
    #2;
    chk_off("reset_mid");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("rel_phase", 64'(phase), 64'h1);
    chk("rel_buf", 64'(buf_idx), 64'h0);
    step();
    chk("rel_lost_p", 64'(p_drive), 64'h0);
    chk("rel_lost_rd", 64'(rd_data), 64'h0);

`ifdef PATSEQ_DEADTIME_EN
    wr(0, 0, 'h11); wr(0, 1, 'h22);
    pwm = 1'b0; step(); step();
    dwell = 4'd0; deadtime = 4'd3; pwm = 1'b1;
    step();
    for (int n = 1; n <= 4; n++) begin
      step();
      chk("dead3_p", 64'(p_drive), 64'((n <= 3) ? 'h7F : 'h11));
    end
    deadtime = 4'd0; pwm = 1'b0;
    step();
    step();
    chk("dead0_n", 64'(n_drive), 64'h22);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      wr_en = 1'($urandom_range(0, 1));
      wr_buf = 3'($urandom_range(0, 7));
      wr_field = 5'($urandom_range(0, 31));
      wr_data = 7'($urandom);
      rd_buf = 3'($urandom_range(0, 7));
      rd_field = 5'($urandom_range(0, 31));
      dwell = 4'($urandom_range(0, 3));
      deadtime = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 11) == 0) pwm = ~pwm;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
